// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, register and branch-FSM definitions for the MIPS pipeline.
package mips_pkg;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam int REG_ZERO = 0;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} br_state_t;

    function automatic logic is_branch_op(input logic [5:0] op);
        return op == OP_BEQ || op == OP_BNE;
    endfunction
endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// branch_resolve_unit_cmp: equality comparator for the forwarded branch operands.
module branch_resolve_unit_cmp #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);
    assign eq = a == b;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch resolution with forwarding, hazard stalls,
// PC redirect and saturating branch statistics.
module branch_resolve_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IdBeq,
    input  logic              IdBne,
    input  logic [REG_W-1:0]  IdRs,
    input  logic [REG_W-1:0]  IdRt,
    input  logic [DATA_W-1:0] IdReadData1,
    input  logic [DATA_W-1:0] IdReadData2,
    input  logic [DATA_W-1:0] IdPcPlus4,
    input  logic [DATA_W-1:0] IdImmExt,
    input  logic              ExRegWrite,
    input  logic              ExMemRead,
    input  logic [REG_W-1:0]  ExWriteReg,
    input  logic              MemRegWrite,
    input  logic              MemMemRead,
    input  logic [REG_W-1:0]  MemWriteReg,
    input  logic [DATA_W-1:0] MemAluResult,
    output logic              PcWrite,
    output logic              IfIdWrite,
    output logic              IdExBubble,
    output logic              IfIdFlush,
    output logic              BranchTaken,
    output logic [DATA_W-1:0] BranchTarget,
    output logic [CNT_W-1:0]  BranchCount,
    output logic [CNT_W-1:0]  TakenCount,
    output logic [CNT_W-1:0]  StallCount
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    br_state_t         state_q, state_d;
    logic [1:0]        stall_left_q, stall_left_d;
    logic [CNT_W-1:0]  branch_count_q, branch_count_d;
    logic [CNT_W-1:0]  taken_count_q, taken_count_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [1:0]        need_rs, need_rt, need;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;
    logic              branch, stall, resolve, equal;

    // Stalls a source register needs before its value is visible to ID.
    function automatic logic [1:0] src_need(
        input logic [REG_W-1:0] s,
        input logic             ex_rw,
        input logic             ex_mr,
        input logic [REG_W-1:0] ex_wr,
        input logic             mem_rw,
        input logic             mem_mr,
        input logic [REG_W-1:0] mem_wr
    );
        return s == REG_W'(REG_ZERO)       ? 2'd0 :
               ex_rw && ex_wr == s         ? (ex_mr ? 2'd2 : 2'd1) :
               mem_rw && mem_mr && mem_wr == s ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_W-1:0]  s,
        input logic [DATA_W-1:0] rf
    );
        return (s != REG_W'(REG_ZERO) && MemRegWrite && !MemMemRead && MemWriteReg == s)
               ? MemAluResult : rf;
    endfunction

    branch_resolve_unit_cmp #(.W(DATA_W)) u_cmp (
        .a  (fwd_rs),
        .b  (fwd_rt),
        .eq (equal)
    );

    always_comb begin
        branch       = IdBeq || IdBne;
        need_rs      = src_need(IdRs, ExRegWrite, ExMemRead, ExWriteReg, MemRegWrite, MemMemRead, MemWriteReg);
        need_rt      = src_need(IdRt, ExRegWrite, ExMemRead, ExWriteReg, MemRegWrite, MemMemRead, MemWriteReg);
        need         = need_rs > need_rt ? need_rs : need_rt;
        fwd_rs       = fwd(IdRs, IdReadData1);
        fwd_rt       = fwd(IdRt, IdReadData2);
        stall        = state_q == ST_WAIT || (branch && need != 2'd0);
        resolve      = branch && !stall;
        BranchTaken  = resolve && ((IdBeq && equal) || (IdBne && !equal));
        IfIdFlush    = BranchTaken;
        PcWrite      = !stall;
        IfIdWrite    = !stall;
        IdExBubble   = stall;
        BranchTarget = IdPcPlus4 + (IdImmExt << 2);
        // In WAIT the counter is at least 1, so reaching 1 means this is the last stall.
        stall_left_d = state_q == ST_WAIT ? stall_left_q - 2'd1 :
                       stall              ? need - 2'd1 : stall_left_q;
        state_d      = state_q == ST_WAIT ? (stall_left_q == 2'd1 ? ST_IDLE : ST_WAIT) :
                       (stall && need > 2'd1) ? ST_WAIT : ST_IDLE;
        branch_count_d = branch_count_q + CNT_W'(resolve && branch_count_q != CNT_MAX);
        taken_count_d  = taken_count_q + CNT_W'(BranchTaken && taken_count_q != CNT_MAX);
        stall_count_d  = stall_count_q + CNT_W'(stall && stall_count_q != CNT_MAX);
        BranchCount  = branch_count_q;
        TakenCount   = taken_count_q;
        StallCount   = stall_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            stall_left_q   <= 2'd0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
            stall_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            stall_left_q   <= stall_left_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
            stall_count_q  <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table-driven single-cycle vectors plus hand-written
// multi-cycle stall, reset and saturation sequences.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IdBeq, IdBne, ExRegWrite, ExMemRead, MemRegWrite, MemMemRead;
    logic [4:0]  IdRs, IdRt, ExWriteReg, MemWriteReg;
    logic [31:0] IdReadData1, IdReadData2, IdPcPlus4, IdImmExt, MemAluResult;
    logic        PcWrite, IfIdWrite, IdExBubble, IfIdFlush, BranchTaken;
    logic [31:0] BranchTarget;
    logic [15:0] BranchCount, TakenCount, StallCount;
    logic        s_PcWrite, s_IfIdWrite, s_IdExBubble, s_IfIdFlush, s_BranchTaken;
    logic [31:0] s_BranchTarget;
    logic [1:0]  s_BranchCount, s_TakenCount, s_StallCount;
    int checks = 0;
    int failures = 0;
    int exp_b = 0, exp_t = 0, exp_s = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .reset(reset), .IdBeq(IdBeq), .IdBne(IdBne), .IdRs(IdRs), .IdRt(IdRt),
        .IdReadData1(IdReadData1), .IdReadData2(IdReadData2), .IdPcPlus4(IdPcPlus4),
        .IdImmExt(IdImmExt), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .ExWriteReg(ExWriteReg), .MemRegWrite(MemRegWrite), .MemMemRead(MemMemRead),
        .MemWriteReg(MemWriteReg), .MemAluResult(MemAluResult), .PcWrite(PcWrite),
        .IfIdWrite(IfIdWrite), .IdExBubble(IdExBubble), .IfIdFlush(IfIdFlush),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .BranchCount(BranchCount),
        .TakenCount(TakenCount), .StallCount(StallCount)
    );

    branch_resolve_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .IdBeq(IdBeq), .IdBne(IdBne), .IdRs(IdRs), .IdRt(IdRt),
        .IdReadData1(IdReadData1), .IdReadData2(IdReadData2), .IdPcPlus4(IdPcPlus4),
        .IdImmExt(IdImmExt), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .ExWriteReg(ExWriteReg), .MemRegWrite(MemRegWrite), .MemMemRead(MemMemRead),
        .MemWriteReg(MemWriteReg), .MemAluResult(MemAluResult), .PcWrite(s_PcWrite),
        .IfIdWrite(s_IfIdWrite), .IdExBubble(s_IdExBubble), .IfIdFlush(s_IfIdFlush),
        .BranchTaken(s_BranchTaken), .BranchTarget(s_BranchTarget), .BranchCount(s_BranchCount),
        .TakenCount(s_TakenCount), .StallCount(s_StallCount)
    );

    typedef struct {
        string       name;
        logic        beq, bne;
        logic [4:0]  rs, rt;
        logic [31:0] rd1, rd2, pc, imm;
        logic        exrw, exmr;
        logic [4:0]  exwr;
        logic        memrw, memmr;
        logic [4:0]  memwr;
        logic [31:0] memalu;
        logic        e_pcw, e_taken;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(
        input string nm, input logic beq, bne, input logic [4:0] rs, rt,
        input logic [31:0] rd1, rd2, pc, imm, input logic exrw, exmr, input logic [4:0] exwr,
        input logic memrw, memmr, input logic [4:0] memwr, input logic [31:0] memalu,
        input logic e_pcw, e_taken, input logic [31:0] e_tgt
    );
        vec_t v;
        v.name = nm; v.beq = beq; v.bne = bne; v.rs = rs; v.rt = rt;
        v.rd1 = rd1; v.rd2 = rd2; v.pc = pc; v.imm = imm;
        v.exrw = exrw; v.exmr = exmr; v.exwr = exwr;
        v.memrw = memrw; v.memmr = memmr; v.memwr = memwr; v.memalu = memalu;
        v.e_pcw = e_pcw; v.e_taken = e_taken; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        IdBeq = 0; IdBne = 0; IdRs = 0; IdRt = 0; IdReadData1 = 0; IdReadData2 = 0;
        IdPcPlus4 = 32'h100; IdImmExt = 3; ExRegWrite = 0; ExMemRead = 0; ExWriteReg = 0;
        MemRegWrite = 0; MemMemRead = 0; MemWriteReg = 0; MemAluResult = 0;
    endtask

    task automatic apply(input vec_t v);
        IdBeq = v.beq; IdBne = v.bne; IdRs = v.rs; IdRt = v.rt;
        IdReadData1 = v.rd1; IdReadData2 = v.rd2; IdPcPlus4 = v.pc; IdImmExt = v.imm;
        ExRegWrite = v.exrw; ExMemRead = v.exmr; ExWriteReg = v.exwr;
        MemRegWrite = v.memrw; MemMemRead = v.memmr; MemWriteReg = v.memwr; MemAluResult = v.memalu;
    endtask

    task automatic chk_flow(input string nm, input logic pcw, input logic taken);
        chk({nm, ".PcWrite"}, 32'(PcWrite), 32'(pcw));
        chk({nm, ".IfIdWrite"}, 32'(IfIdWrite), 32'(pcw));
        chk({nm, ".IdExBubble"}, 32'(IdExBubble), 32'(!pcw));
        chk({nm, ".BranchTaken"}, 32'(BranchTaken), 32'(taken));
        chk({nm, ".IfIdFlush"}, 32'(IfIdFlush), 32'(taken));
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, ".BranchCount"}, 32'(BranchCount), 32'(exp_b));
        chk({nm, ".TakenCount"}, 32'(TakenCount), 32'(exp_t));
        chk({nm, ".StallCount"}, 32'(StallCount), 32'(exp_s));
    endtask

    initial begin
        vecs[0]  = mk("nobr",          0,0,1,2,5,5,32'h100,3,               1,1,1, 0,0,0,0, 1,0,32'h10C);
        vecs[1]  = mk("beq_eq",        1,0,1,2,5,5,32'h100,3,               0,0,0, 0,0,0,0, 1,1,32'h10C);
        vecs[2]  = mk("beq_ne",        1,0,1,2,5,6,32'h200,32'h10,          0,0,0, 0,0,0,0, 1,0,32'h240);
        vecs[3]  = mk("bne_ne",        0,1,1,2,5,6,32'h200,32'h10,          0,0,0, 0,0,0,0, 1,1,32'h240);
        vecs[4]  = mk("bne_eq",        0,1,3,4,7,7,32'h40,32'hFFFFFFFF,     0,0,0, 0,0,0,0, 1,0,32'h3C);
        vecs[5]  = mk("beq_neg",       1,0,3,4,8,8,32'h100,32'hFFFFFFFE,    0,0,0, 0,0,0,0, 1,1,32'hF8);
        vecs[6]  = mk("tgt_wrap",      1,0,3,4,1,2,32'hFFFFFFFC,1,          0,0,0, 0,0,0,0, 1,0,32'h0);
        vecs[7]  = mk("mem_fwd_rs",    1,0,4,5,0,7,32'h100,3,               0,0,0, 1,0,4,7, 1,1,32'h10C);
        vecs[8]  = mk("mem_fwd_rt",    0,1,3,6,9,0,32'h100,3,               0,0,0, 1,0,6,9, 1,0,32'h10C);
        vecs[9]  = mk("reg0",          1,0,0,3,0,5,32'h100,3,               1,1,0, 1,0,0,5, 1,0,32'h10C);
        vecs[10] = mk("ex_alu_stall",  0,1,8,2,1,2,32'h100,3,               1,0,8, 0,0,0,0, 0,0,32'h10C);
        vecs[11] = mk("mem_load_stall",1,0,2,9,4,4,32'h100,3,               0,0,0, 1,1,9,0, 0,0,32'h10C);
        vecs[12] = mk("ex_no_write",   1,0,1,2,3,3,32'h100,3,               0,1,1, 0,0,0,0, 1,1,32'h10C);
        vecs[13] = mk("both_haz",      0,1,7,8,1,2,32'h100,3,               1,0,7, 1,1,8,0, 0,0,32'h10C);

        clr();
        #1;
        chk_flow("reset", 1, 0);
        chk_cnt("reset");
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            #1;
            chk_flow(vecs[i].name, vecs[i].e_pcw, vecs[i].e_taken);
            chk({vecs[i].name, ".BranchTarget"}, BranchTarget, vecs[i].e_tgt);
            if ((vecs[i].beq || vecs[i].bne) && vecs[i].e_pcw) exp_b++;
            if (vecs[i].e_taken) exp_t++;
            if (!vecs[i].e_pcw) exp_s++;
            @(posedge clk);
            #1;
            chk_cnt(vecs[i].name);
            @(negedge clk);
        end

        // EX ALU hazard: one stall, then the add has moved to MEM and is forwarded
        clr();
        IdBne = 1; IdRs = 8; IdRt = 2; IdReadData1 = 0; IdReadData2 = 4;
        ExRegWrite = 1; ExWriteReg = 8;
        #1;
        chk_flow("exalu.c1", 0, 0);
        @(negedge clk);
        ExRegWrite = 0; ExWriteReg = 0;
        MemRegWrite = 1; MemWriteReg = 8; MemAluResult = 3;
        #1;
        chk_flow("exalu.c2", 1, 1);
        exp_b++; exp_t++; exp_s++;
        @(posedge clk);
        #1;
        chk_cnt("exalu.after");

        // EX load hazard: two stalls; the second must hold even with no visible hazard
        @(negedge clk);
        clr();
        IdBeq = 1; IdRs = 1; IdRt = 9; IdReadData1 = 32'h55; IdReadData2 = 0;
        ExRegWrite = 1; ExMemRead = 1; ExWriteReg = 9;
        #1;
        chk_flow("exload.c1", 0, 0);
        @(negedge clk);
        ExRegWrite = 0; ExMemRead = 0; ExWriteReg = 0;
        #1;
        chk_flow("exload.c2", 0, 0);
        @(negedge clk);
        IdReadData2 = 32'h55;
        #1;
        chk_flow("exload.c3", 1, 1);
        chk("exload.c3.BranchTarget", BranchTarget, 32'h10C);
        exp_b++; exp_t++; exp_s += 2;
        @(posedge clk);
        #1;
        chk_cnt("exload.after");
        chk("small.BranchCount_sat", 32'(s_BranchCount), 32'd3);
        chk("small.TakenCount_sat", 32'(s_TakenCount), 32'd3);
        chk("small.StallCount_sat", 32'(s_StallCount), 32'd3);

        // Reset while in WAIT: the stall is released immediately
        @(negedge clk);
        clr();
        IdBeq = 1; IdRt = 9; ExRegWrite = 1; ExMemRead = 1; ExWriteReg = 9;
        @(negedge clk);
        clr();
        #1;
        chk_flow("wait.nobranch", 0, 0);
        reset = 1;
        #1;
        exp_b = 0; exp_t = 0; exp_s = 0;
        chk_flow("wait.reset", 1, 0);
        chk_cnt("wait.reset");
        @(negedge clk);
        reset = 0;
        #1;
        chk_flow("post_reset", 1, 0);

        // Saturation of the 16-bit counters
        IdBeq = 1; IdRs = 1; IdRt = 2; IdReadData1 = 6; IdReadData2 = 6;
        for (int i = 0; i < 65537; i++) @(posedge clk);
        #1;
        chk("sat.BranchCount", 32'(BranchCount), 32'hFFFF);
        chk("sat.TakenCount", 32'(TakenCount), 32'hFFFF);
        chk("sat.StallCount", 32'(StallCount), 32'h0);
        @(posedge clk);
        #1;
        chk("sat.BranchCount_hold", 32'(BranchCount), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
